// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Read-owner tag and byte-enable codes used by the arbiter and its users.
package dmem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  localparam logic [3:0] MEM_BE_NONE = 4'b0000;
  localparam logic [3:0] MEM_BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Saturating starvation counter: inc counts denied cycles, clr restarts.
// Ports: clk, rst_n, inc, clr in; at_limit out (never set when LIMIT=0).
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_limit = (LIMIT != 0) && (r_cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: core LSU has priority,
// aux master is forced through after STARVE_LIMIT denied cycles.
// Ports: core_* (LSU), aux_* (req/gnt master), mem_* (sync SRAM, 1-cycle read).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_cs_n,
  input  logic              core_rd,
  input  logic [3:0]        core_mask,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [3:0]        aux_be,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [31:0]       aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [31:0]       aux_rdata,
  output logic              mem_cs_n,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  owner_e r_owner;
  owner_e w_owner_d;
  logic   w_creq;
  logic   w_force;
  logic   w_aux_win;
  logic   w_core_win;
  logic   w_unused;

  // Grants are gated by rst_n so the port is idle while in reset.
  assign w_creq     = rst_n && !core_cs_n;
  assign w_aux_win  = rst_n && aux_req && (!w_creq || w_force);
  assign w_core_win = w_creq && !w_aux_win;

  assign core_stall = w_creq && w_aux_win;
  assign aux_gnt    = w_aux_win;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (aux_req && !w_aux_win),
    .clr      (w_aux_win || !aux_req),
    .at_limit (w_force)
  );

  always_comb begin
    mem_cs_n  = 1'b1;
    mem_we    = 1'b0;
    mem_be    = MEM_BE_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    w_owner_d = OWN_NONE;
    unique case (1'b1)
      w_aux_win: begin
        mem_cs_n  = 1'b0;
        mem_we    = aux_we;
        mem_be    = aux_we ? aux_be : MEM_BE_NONE;
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        w_owner_d = aux_we ? OWN_NONE : OWN_AUX;
      end
      w_core_win: begin
        mem_cs_n  = 1'b0;
        mem_we    = !core_rd;
        mem_be    = core_rd ? MEM_BE_NONE : core_mask;
        mem_addr  = core_addr[ADDR_W+1:2];
        mem_wdata = core_wdata;
        w_owner_d = core_rd ? OWN_CORE : OWN_NONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_d;
    end
  end

  assign core_rvalid = (r_owner == OWN_CORE);
  assign aux_rvalid  = (r_owner == OWN_AUX);
  assign core_rdata  = mem_rdata;
  assign aux_rdata   = mem_rdata;

  // Upper/byte-offset address bits fall outside the memory word space.
  assign w_unused = ^{core_addr[31:ADDR_W+2], core_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural sync SRAM.
// A second instance with STARVE_LIMIT=0 checks pure core priority.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_cs_n = 1'b1;
  logic          core_rd = 1'b0;
  logic [3:0]    core_mask = '0;
  logic [31:0]   core_addr = '0;
  logic [31:0]   core_wdata = '0;
  logic          aux_req = 1'b0;
  logic          aux_req0 = 1'b0;
  logic          aux_we = 1'b0;
  logic [3:0]    aux_be = '0;
  logic [AW-1:0] aux_addr = '0;
  logic [31:0]   aux_wdata = '0;

  logic          core_stall, core_rvalid, aux_gnt, aux_rvalid;
  logic [31:0]   core_rdata, aux_rdata;
  logic          mem_cs_n, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  logic          z_stall, z_crv, z_gnt, z_arv;
  logic [31:0]   z_crd, z_ard, z_wd;
  logic          z_cs_n, z_we;
  logic [3:0]    z_be;
  logic [AW-1:0] z_addr;

  logic [31:0]   mem [0:4095];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] cq[$];
  logic [31:0] aq[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_cs_n(core_cs_n), .core_rd(core_rd), .core_mask(core_mask),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_be(aux_be),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_cs_n(mem_cs_n), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .core_cs_n(core_cs_n), .core_rd(core_rd), .core_mask(core_mask),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(z_stall), .core_rvalid(z_crv), .core_rdata(z_crd),
    .aux_req(aux_req0), .aux_we(aux_we), .aux_be(aux_be),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(z_gnt), .aux_rvalid(z_arv), .aux_rdata(z_ard),
    .mem_cs_n(z_cs_n), .mem_we(z_we), .mem_be(z_be),
    .mem_addr(z_addr), .mem_wdata(z_wd), .mem_rdata(32'h0)
  );

  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_rvalid) begin
        if (cq.size() == 0) chk("core_rv_unexp", 32'(core_rvalid), 32'h0);
        else chk("core_rdata", core_rdata, cq.pop_front());
      end
      if (aux_rvalid) begin
        if (aq.size() == 0) chk("aux_rv_unexp", 32'(aux_rvalid), 32'h0);
        else chk("aux_rdata", aux_rdata, aq.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic core_op(input logic rd, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    core_cs_n  = 1'b0;
    core_rd    = rd;
    core_mask  = m;
    core_addr  = a;
    core_wdata = d;
  endtask

  task automatic core_idle();
    core_cs_n = 1'b1;
    core_rd   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[4] = 32'hDEAD_BEEF;

    // Reset: requests present but the port must stay idle.
    core_op(1'b1, 4'h0, 32'h10, 32'h0);
    aux_req = 1'b1;
    @(negedge clk);
    chk("rst_cs_n", 32'(mem_cs_n), 32'h1);
    chk("rst_gnt", 32'(aux_gnt), 32'h0);
    chk("rst_stall", 32'(core_stall), 32'h0);
    chk("rst_crv", 32'(core_rvalid), 32'h0);
    chk("rst_arv", 32'(aux_rvalid), 32'h0);
    nxt();
    core_idle();
    aux_req = 1'b0;
    rst_n = 1'b1;
    nxt();

    // Core load of word 4.
    core_op(1'b1, 4'hF, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("ld_addr", 32'(mem_addr), 32'd4);
    chk("ld_be", 32'(mem_be), 32'h0);
    chk("ld_cs_n", 32'(mem_cs_n), 32'h0);
    chk("ld_we", 32'(mem_we), 32'h0);
    chk("ld_stall", 32'(core_stall), 32'h0);
    cq.push_back(32'hDEAD_BEEF);
    nxt();
    core_idle();
    @(negedge clk);
    chk("ld_rv", 32'(core_rvalid), 32'h1);
    nxt();

    // Core partial store to word 2.
    core_op(1'b0, 4'b1100, 32'h0000_0008, 32'h1234_0000);
    @(negedge clk);
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_be", 32'(mem_be), 32'hC);
    chk("st_addr", 32'(mem_addr), 32'd2);
    chk("st_wd", mem_wdata, 32'h1234_0000);
    nxt();
    core_idle();
    @(negedge clk);
    chk("st_crv", 32'(core_rvalid), 32'h0);
    chk("st_arv", 32'(aux_rvalid), 32'h0);
    nxt();

    // Starvation: aux write held against continuous core loads.
    aux_req   = 1'b1;
    aux_we    = 1'b1;
    aux_be    = MEM_BE_WORD;
    aux_addr  = 12'h030;
    aux_wdata = 32'hA5A5_A5A5;
    core_op(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("sv_gnt%0d", c), 32'(aux_gnt), 32'h0);
      chk($sformatf("sv_stall%0d", c), 32'(core_stall), 32'h0);
      cq.push_back(32'hDEAD_BEEF);
      nxt();
    end
    @(negedge clk);
    chk("sv_gnt5", 32'(aux_gnt), 32'h1);
    chk("sv_stall5", 32'(core_stall), 32'h1);
    chk("sv_addr5", 32'(mem_addr), 32'h030);
    chk("sv_we5", 32'(mem_we), 32'h1);
    nxt();
    aux_req = 1'b0;
    aux_we  = 1'b0;
    @(negedge clk);
    chk("sv_cnt0", 32'(dut.u_starve.r_cnt), 32'h0);
    chk("sv_gnt6", 32'(aux_gnt), 32'h0);
    chk("sv_stall6", 32'(core_stall), 32'h0);
    chk("sv_addr6", 32'(mem_addr), 32'd4);
    cq.push_back(32'hDEAD_BEEF);
    nxt();
    core_idle();
    nxt();
    nxt();
    chk("cq_empty1", 32'(cq.size()), 32'h0);

    // Interleaved reads: core word 1, then aux word 2 (after partial store).
    core_op(1'b1, 4'h0, 32'h0000_0004, 32'h0);
    cq.push_back(32'h1111_1111);
    nxt();
    core_idle();
    aux_req  = 1'b1;
    aux_we   = 1'b0;
    aux_addr = 12'h002;
    @(negedge clk);
    chk("il_gnt", 32'(aux_gnt), 32'h1);
    chk("il_crv1", 32'(core_rvalid), 32'h1);
    chk("il_arv1", 32'(aux_rvalid), 32'h0);
    aq.push_back(32'h1234_2222);
    nxt();
    aux_req = 1'b0;
    @(negedge clk);
    chk("il_crv2", 32'(core_rvalid), 32'h0);
    chk("il_arv2", 32'(aux_rvalid), 32'h1);
    nxt();
    nxt();
    chk("aq_empty", 32'(aq.size()), 32'h0);

    // Read right after an aux write to the same word sees new data.
    core_op(1'b1, 4'h0, 32'h0000_00C0, 32'h0);
    cq.push_back(32'hA5A5_A5A5);
    nxt();
    core_idle();
    nxt();
    nxt();

    // STARVE_LIMIT=0 instance: aux never wins against core traffic.
    aux_req0 = 1'b1;
    aux_we   = 1'b1;
    core_op(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("l0_gnt", 32'(z_gnt), 32'h0);
      cq.push_back(32'hDEAD_BEEF);
      nxt();
    end
    core_idle();
    @(negedge clk);
    chk("l0_gnt_idle", 32'(z_gnt), 32'h1);
    nxt();
    aux_req0 = 1'b0;
    aux_we   = 1'b0;
    nxt();
    nxt();
    chk("cq_empty2", 32'(cq.size()), 32'h0);

    // Reset while a core read is in flight.
    aux_req = 1'b1;
    aux_addr = 12'h001;
    core_op(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("rm_cs_n", 32'(mem_cs_n), 32'h0);
    nxt();
    rst_n = 1'b0;
    core_idle();
    aux_req = 1'b0;
    @(negedge clk);
    chk("rm_crv", 32'(core_rvalid), 32'h0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_crv_post", 32'(core_rvalid), 32'h0);
    chk("rm_cnt", 32'(dut.u_starve.r_cnt), 32'h0);
    nxt();
    core_op(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    chk("pr_addr", 32'(mem_addr), 32'd4);
    chk("pr_cs_n", 32'(mem_cs_n), 32'h0);
    cq.push_back(32'hDEAD_BEEF);
    nxt();
    core_idle();
    @(negedge clk);
    chk("pr_rv", 32'(core_rvalid), 32'h1);
    nxt();
    nxt();
    chk("cq_empty3", 32'(cq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the core's load/store unit (priority port) and an auxiliary master (loader/debug/DMA).
- Fixed core priority, with a starvation counter that forces an aux grant after STARVE_LIMIT consecutive denied cycles.
- Stalls the pipeline while the aux master owns the port.
- Returns read data one cycle after issue and tags it to the requester that issued the read.

Parameters:
- ADDR_W, 12, word-address width of the data memory.
- STARVE_LIMIT, 4, consecutive denied aux cycles before the aux master is forced a grant; 0 disables forcing (pure core priority).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_cs_n  in  1  core request, active low (LSU chip select).
- core_rd  in  1  1 = load, 0 = store.
- core_mask  in  4  store byte enables; ignored on loads (load-type code).
- core_addr  in  32  byte address; word address = core_addr[ADDR_W+1:2].
- core_wdata  in  32  store data.
- core_stall  out  1  core request present but not granted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  32  raw memory word.
- aux_req  in  1  aux request, level, held until granted.
- aux_we  in  1  1 = write.
- aux_be  in  4  write byte enables.
- aux_addr  in  ADDR_W  word address.
- aux_wdata  in  32  write data.
- aux_gnt  out  1  single-cycle grant pulse.
- aux_rvalid  out  1  aux read data valid.
- aux_rdata  out  32  raw memory word.
- mem_cs_n  out  1  memory select, active low.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables; 0000 on reads.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read word, valid the cycle after a read issue.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - starve_cnt = 0, rd_owner = NONE, core_rvalid = 0, aux_rvalid = 0.
  - Combinational outputs under reset: mem_cs_n = 1, aux_gnt = 0, core_stall = 0.
- Issue cycle (combinational from inputs and starve_cnt):
  - Request terms: creq = !core_cs_n; force = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_LIMIT).
  - Aux wins when aux_req && (!creq || force). Otherwise, core wins when creq.
  - The winner drives mem_*. mem_cs_n = 0 only when someone is granted.
  - Core store: mem_we = 1, mem_be = core_mask. Core load: mem_we = 0, mem_be = 0000.
  - Aux access: mem_we = aux_we, mem_be = aux_we ? aux_be : 0000.
  - core_stall = creq && aux wins. aux_gnt = aux wins.
- Read return:
  - On a granted read, rd_owner <= CORE or AUX at the clock edge; otherwise rd_owner <= NONE.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rvalid = 0.
  - rdata is don't-care when rvalid = 0. It is driven as mem_rdata, no extra register.
  - Read latency is 1 cycle. Back-to-back issue every cycle is supported.
- Starvation counter:
  - Increments each cycle aux_req = 1 and not granted, saturating at STARVE_LIMIT.
  - Clears on aux grant or when aux_req = 0.
  - Forced grants last exactly one cycle. Core priority resumes the following cycle.
- Handshake rules:
  - aux holds req, we, be, addr and wdata stable until it sees aux_gnt. A request is consumed at the edge ending the grant cycle.
  - aux may present a new request in the cycle after the grant.
  - Core holds its request stable while core_stall = 1. The LSU/pipeline freeze guarantees this.
- Simultaneous accesses to the same address are ordered by grant. A read issued in the cycle after a write to the same word returns the new data.
- Out-of-range address: upper core_addr bits are ignored. There is no error response.
- Reset mid-operation: the in-flight read is discarded (no rvalid after reset) and the counter is cleared.

Decomposition:
- Shared package dmem_pkg:
  - owner_e enum {OWN_NONE, OWN_CORE, OWN_AUX}.
  - Constants MEM_BE_NONE = 4'b0000 and MEM_BE_WORD = 4'b1111.
- Sub-module starve_counter: saturating counter with inc, clr, limit and at_limit; instantiated once.

Test Plan:
- Core load at 0x0000_0010 alone, mem holds 0xDEADBEEF at word 4 -> mem_addr=4, mem_be=0000, mem_cs_n=0; next cycle core_rvalid=1, core_rdata=0xDEADBEEF, core_stall=0.
- Core store, mask 4'b1100, addr 0x0000_0008, wdata 0x12340000, with aux_req idle -> mem_we=1, mem_be=1100, mem_addr=2; no rvalid on either port.
- Aux write held while the core issues continuously, STARVE_LIMIT=4 -> aux_gnt on the 5th cycle, core_stall=1 that cycle only, counter back to 0, core granted the next cycle.
- Interleaved reads: core read word 1 in cycle N, aux read word 2 in cycle N+1 -> core_rvalid in N+1 only, aux_rvalid in N+2 only, each with its own word.
- STARVE_LIMIT=0, aux_req held for 20 cycles of continuous core traffic -> aux_gnt never asserted; aux granted the first cycle core_cs_n=1.
- rst_n dropped the cycle after a core read grant -> core_rvalid stays 0 and the counter reads 0 after release; the first post-reset access behaves as the first scenario.
